// File: rtl/alu_sweep_checker.sv
// rtl/alu_sweep_checker.sv - on-board sweep generator and self-checker for the 4-bit ALU
module alu_sweep_checker #(
  parameter int HOLD         = 1,
  parameter int ERRW         = 12,
  parameter int STOP_ON_FAIL = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [3:0]      rd_in,
  output logic [2:0]      sel_out,
  output logic [3:0]      rs_out,
  output logic [3:0]      rt_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [ERRW-1:0] err_count,
  output logic            fail_valid,
  output logic [10:0]     fail_vec,
  output logic [3:0]      fail_rd
);

  // Hold counter only needs to reach HOLD-1; keep at least one bit.
  localparam int HCW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD - 1);
  localparam logic [10:0] VEC_LAST = 11'h7FF;
  localparam logic [ERRW-1:0] ERR_ONE = {{(ERRW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state;
  logic [HCW-1:0]  hold_cnt;
  logic [10:0]     vec;

  logic [3:0]      expected;
  logic            mismatch;
  logic [ERRW-1:0] err_next;
  logic            last_vec;

  // Reference result of the ALU for a given opcode and operand pair.
  function automatic logic [3:0] golden(input logic [2:0] sel,
                                        input logic [3:0] rs,
                                        input logic [3:0] rt);
    logic [3:0] r;
    case (sel)
      3'b000:  r = rs + rt;
      3'b001:  r = rs - rt;
      3'b010:  r = rs & rt;
      3'b011:  r = rs | rt;
      3'b100:  r = {rs[2:0], rs[3]};
      3'b101:  r = {rt[3], rt[3:1]};
      3'b110:  r = (rs == rt) ? 4'b1111 : 4'b1110;
      3'b111:  r = (rs > rt) ? 4'b1011 : 4'b1010;
      default: r = 4'b0000;
    endcase
    return r;
  endfunction

  // The ALU operands come straight from the vector register.
  assign sel_out = vec[10:8];
  assign rs_out  = vec[7:4];
  assign rt_out  = vec[3:0];

  // Compare the sampled result; X/Z on rd_in must count as a mismatch.
  always_comb begin
    expected = golden(vec[10:8], vec[7:4], vec[3:0]);
    mismatch = (rd_in !== expected);
    err_next = (err_count == {ERRW{1'b1}}) ? err_count : (err_count + ERR_ONE);
    last_vec = (vec == VEC_LAST);
  end

  // Sweep controller: IDLE/DONE wait for start, RUN steps through all 2048 vectors.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      hold_cnt   <= '0;
      vec        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      fail_vec   <= '0;
      fail_rd    <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state      <= S_RUN;
            hold_cnt   <= '0;
            vec        <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_vec   <= '0;
            fail_rd    <= '0;
          end
        end

        S_RUN: begin
          if (abort) begin
            // Abort wins over a compare due this cycle; results so far are kept.
            state    <= S_IDLE;
            hold_cnt <= '0;
            busy     <= 1'b0;
          end else if (hold_cnt != HOLD_LAST) begin
            hold_cnt <= hold_cnt + 1'b1;
          end else begin
            hold_cnt <= '0;
            if (mismatch) begin
              err_count <= err_next;
              if (!fail_valid) begin
                fail_valid <= 1'b1;
                fail_vec   <= vec;
                fail_rd    <= rd_in;
              end
            end
            if (last_vec || ((STOP_ON_FAIL != 0) && mismatch)) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= !mismatch && (err_count == '0);
            end else begin
              vec <= vec + 11'd1;
            end
          end
        end

        default: begin
          state    <= S_IDLE;
          hold_cnt <= '0;
          busy     <= 1'b0;
          done     <= 1'b0;
          pass     <= 1'b0;
        end
      endcase
    end
  end

endmodule
